// File: rtl/raymarch_pkg.sv
// raymarch_pkg: shared pixel types and colour conversion for the raymarcher back end
package raymarch_pkg;
   localparam int DEFAULT_WIDTH  = 1280;
   localparam int DEFAULT_HEIGHT = 720;
   typedef logic [15:0] rgb565_t;
   typedef struct packed {
      logic [$clog2(DEFAULT_WIDTH)-1:0]  x;
      logic [$clog2(DEFAULT_HEIGHT)-1:0] y;
      rgb565_t                           rgb;
   } pix_entry_t;
   function automatic rgb565_t rgb888_to_565(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      return {r[7:3], g[7:2], b[7:3]};
   endfunction
endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: synchronous FIFO of pixel entries with push/pop/full/empty
// A push while full is accepted only when a pop frees the slot the same cycle.
module pixel_fifo
   import raymarch_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = pix_entry_t
) (
   input  logic clk_pixel_in,
   input  logic rst_in,
   input  logic push,
   input  logic pop,
   input  T     wr_data,
   output T     rd_data,
   output logic full,
   output logic empty
);
   localparam int AW = $clog2(DEPTH);
   T            mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic        do_push, do_pop;
   assign empty   = wr_ptr == rd_ptr;
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr[AW-1:0]];
   always_ff @(posedge clk_pixel_in or negedge rst_in)
      if (!rst_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   always_ff @(posedge clk_pixel_in)
      if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
endmodule

// File: rtl/pixel_writeback.sv
// pixel_writeback: sequences raster coordinates and commits finished pixels to the frame buffer
// Finished pixels are captured on the rising edge of pixel_done, buffered, and written over valid/ready.
module pixel_writeback
   import raymarch_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter int HEIGHT     = DEFAULT_HEIGHT,
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = $clog2(WIDTH*HEIGHT)
) (
   input  logic                      clk_pixel_in,
   input  logic                      rst_in,
   input  logic                      pixel_done,
   input  logic [$clog2(WIDTH)-1:0]  out_x,
   input  logic [$clog2(HEIGHT)-1:0] out_y,
   input  logic [7:0]                red_out,
   input  logic [7:0]                green_out,
   input  logic [7:0]                blue_out,
   output logic [$clog2(WIDTH)-1:0]  curr_x,
   output logic [$clog2(HEIGHT)-1:0] curr_y,
   output logic                      fb_valid,
   input  logic                      fb_ready,
   output logic [ADDR_W-1:0]         fb_addr,
   output logic [15:0]               fb_data,
   output logic                      frame_done,
   output logic [7:0]                frame_count,
   output logic                      overflow
);
   localparam int XW = $clog2(WIDTH);
   localparam int YW = $clog2(HEIGHT);
   typedef struct packed {
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      rgb565_t       rgb;
   } entry_t;
   typedef enum logic {EMPTY, HOLD} state_t;
   state_t state;
   entry_t wr_entry, rd_entry;
   logic   done_prev, commit, pop, full, empty, out_last, x_last;
   assign commit   = pixel_done & ~done_prev;
   assign pop      = ~empty & ((state == EMPTY) | fb_ready);
   assign x_last   = curr_x == XW'(WIDTH-1);
   assign wr_entry = {out_x, out_y, rgb888_to_565(red_out, green_out, blue_out)};
   pixel_fifo #(.DEPTH(FIFO_DEPTH), .T(entry_t)) u_fifo (
      .clk_pixel_in(clk_pixel_in),
      .rst_in      (rst_in),
      .push        (commit),
      .pop         (pop),
      .wr_data     (wr_entry),
      .rd_data     (rd_entry),
      .full        (full),
      .empty       (empty)
   );
   always_ff @(posedge clk_pixel_in or negedge rst_in)
      if (!rst_in) begin
         done_prev   <= 1'b1;
         curr_x      <= '0;
         curr_y      <= '0;
         state       <= EMPTY;
         fb_valid    <= 1'b0;
         fb_addr     <= '0;
         fb_data     <= '0;
         out_last    <= 1'b0;
         frame_done  <= 1'b0;
         frame_count <= '0;
         overflow    <= 1'b0;
      end else begin
         done_prev  <= pixel_done;
         frame_done <= 1'b0;
         if (commit) begin
            curr_x <= x_last ? '0 : curr_x + XW'(1);
            if (x_last) curr_y <= (curr_y == YW'(HEIGHT-1)) ? '0 : curr_y + YW'(1);
         end
         if (commit && full && !pop) overflow <= 1'b1;
         if (fb_valid && fb_ready && out_last) begin
            frame_done  <= 1'b1;
            frame_count <= frame_count + 8'd1;
         end
         // Load on EMPTY->HOLD or back-to-back after an accept; otherwise drop to EMPTY on accept.
         if (pop) begin
            state    <= HOLD;
            fb_valid <= 1'b1;
            fb_addr  <= ADDR_W'(rd_entry.y) * ADDR_W'(WIDTH) + ADDR_W'(rd_entry.x);
            fb_data  <= rd_entry.rgb;
            out_last <= (rd_entry.x == XW'(WIDTH-1)) && (rd_entry.y == YW'(HEIGHT-1));
         end else if (fb_ready) begin
            state    <= EMPTY;
            fb_valid <= 1'b0;
         end
      end
endmodule

// File: tb/tb_pixel_writeback.sv
// tb_pixel_writeback: directed self-checking bench for pixel_writeback at WIDTH=8, HEIGHT=4, FIFO_DEPTH=4
module tb_pixel_writeback;
   logic        clk_pixel_in = 1'b0;
   logic        rst_in = 1'b0;
   logic        pixel_done = 1'b1;
   logic [2:0]  out_x = '0;
   logic [1:0]  out_y = '0;
   logic [7:0]  red_out = '0, green_out = '0, blue_out = '0;
   logic [2:0]  curr_x;
   logic [1:0]  curr_y;
   logic        fb_valid, fb_ready = 1'b1;
   logic [4:0]  fb_addr;
   logic [15:0] fb_data;
   logic        frame_done, overflow;
   logic [7:0]  frame_count;
   int          n_cmp = 0, n_err = 0, fd_cnt = 0;
   logic [4:0]  qa[$];
   logic [15:0] qd[$];

   pixel_writeback #(.WIDTH(8), .HEIGHT(4), .FIFO_DEPTH(4)) dut (
      .clk_pixel_in(clk_pixel_in), .rst_in(rst_in), .pixel_done(pixel_done),
      .out_x(out_x), .out_y(out_y), .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
      .curr_x(curr_x), .curr_y(curr_y), .fb_valid(fb_valid), .fb_ready(fb_ready),
      .fb_addr(fb_addr), .fb_data(fb_data), .frame_done(frame_done),
      .frame_count(frame_count), .overflow(overflow)
   );

   always #5 clk_pixel_in = ~clk_pixel_in;

   always @(posedge clk_pixel_in) begin
      if (fb_valid && fb_ready) begin
         qa.push_back(fb_addr);
         qd.push_back(fb_data);
      end
      if (frame_done) fd_cnt++;
   end

   task automatic tick();
      @(posedge clk_pixel_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic commit(input int x, input int y, input logic [7:0] c);
      out_x = 3'(x);
      out_y = 2'(y);
      red_out = c;
      green_out = c;
      blue_out = c;
      pixel_done = 1'b1;
      tick();
      pixel_done = 1'b0;
      tick();
   endtask

   initial begin
      logic [4:0] v;
      #1;
      chk("rst_valid", fb_valid, 0);
      chk("rst_addr", fb_addr, 0);
      chk("rst_data", fb_data, 0);
      chk("rst_fcount", frame_count, 0);
      chk("rst_ovf", overflow, 0);
      tick();
      rst_in = 1'b1;
      repeat (5) tick();
      chk("held_curr_x", curr_x, 0);
      chk("held_curr_y", curr_y, 0);
      chk("held_valid", fb_valid, 0);
      chk("held_nowrite", qa.size(), 0);
      // single pixel (3,2) FF/80/08
      pixel_done = 1'b0;
      tick();
      out_x = 3'd3; out_y = 2'd2;
      red_out = 8'hFF; green_out = 8'h80; blue_out = 8'h08;
      pixel_done = 1'b1;
      tick();
      pixel_done = 1'b0;
      chk("one_curr_x", curr_x, 1);
      chk("one_curr_y", curr_y, 0);
      chk("one_valid_early", fb_valid, 0);
      tick();
      chk("one_valid", fb_valid, 1);
      chk("one_addr", fb_addr, 19);
      chk("one_data", fb_data, 16'hFC01);
      tick();
      chk("one_valid_drop", fb_valid, 0);
      chk("one_writes", qa.size(), 1);
      // full frame from a fresh reset
      rst_in = 1'b0;
      tick();
      rst_in = 1'b1;
      tick();
      qa.delete(); qd.delete(); fd_cnt = 0;
      for (int i = 0; i < 32; i++) begin
         chk("frm_curr_x", curr_x, i % 8);
         chk("frm_curr_y", curr_y, i / 8);
         commit(i % 8, i / 8, 8'(i * 8));
      end
      repeat (4) tick();
      chk("frm_wrap_x", curr_x, 0);
      chk("frm_wrap_y", curr_y, 0);
      chk("frm_pulses", fd_cnt, 1);
      chk("frm_count", frame_count, 1);
      chk("frm_ovf", overflow, 0);
      chk("frm_writes", qa.size(), 32);
      for (int i = 0; i < 32 && i < qa.size(); i++) begin
         v = 5'(i);
         chk("frm_addr", qa[i], i);
         chk("frm_data", qd[i], {v, v, 1'b0, v});
      end
      // overflow with a stalled arbiter
      fb_ready = 1'b0;
      qa.delete(); qd.delete();
      for (int i = 0; i < 6; i++) commit(i, 0, 8'h10);
      chk("ovf_flag", overflow, 1);
      chk("ovf_valid", fb_valid, 1);
      chk("ovf_addr", fb_addr, 0);
      chk("ovf_curr_x", curr_x, 6);
      fb_ready = 1'b1;
      repeat (5) tick();
      chk("ovf_drained", fb_valid, 0);
      chk("ovf_writes", qa.size(), 5);
      for (int i = 0; i < 5 && i < qa.size(); i++) chk("ovf_order", qa[i], i);
      chk("ovf_sticky", overflow, 1);
      // asynchronous reset while holding a write
      fb_ready = 1'b0;
      commit(2, 1, 8'hA0);
      chk("ar_valid_pre", fb_valid, 1);
      chk("ar_addr_pre", fb_addr, 10);
      #2;
      rst_in = 1'b0;
      #1;
      chk("ar_valid", fb_valid, 0);
      chk("ar_addr", fb_addr, 0);
      chk("ar_data", fb_data, 0);
      chk("ar_curr_x", curr_x, 0);
      chk("ar_curr_y", curr_y, 0);
      chk("ar_fcount", frame_count, 0);
      chk("ar_ovf", overflow, 0);
      chk("ar_fdone", frame_done, 0);
      tick();
      rst_in = 1'b1;
      tick();
      // full FIFO with commit and accept on the same cycle
      qa.delete(); qd.delete();
      for (int i = 0; i < 5; i++) commit(i, 0, 8'h20);
      chk("fp_valid", fb_valid, 1);
      chk("fp_ovf_pre", overflow, 0);
      out_x = 3'd5; out_y = 2'd0;
      pixel_done = 1'b1;
      fb_ready = 1'b1;
      tick();
      pixel_done = 1'b0;
      chk("fp_ovf", overflow, 0);
      repeat (6) tick();
      chk("fp_writes", qa.size(), 6);
      for (int i = 0; i < 6 && i < qa.size(); i++) chk("fp_order", qa[i], i);
      chk("fp_valid_end", fb_valid, 0);
      chk("fp_ovf_end", overflow, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
